// File: rtl/dmux_8ch_stream_pkg.sv
// Shared constants and helpers for the 8-channel byte demultiplexer.
// Channel k occupies bits [chan_lsb(k) +: WIDTH] of the flattened output bus.
package dmux_pkg;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 8;
  localparam int SEL_W    = 3;

  function automatic int chan_lsb(input int k);
    return k * WIDTH;
  endfunction

endpackage

// File: rtl/dmux_8ch_stream_if.sv
// Stream bus for the demultiplexer: one tagged input stream, eight output channels.
// master drives the input stream and consumes outputs; slave is the demultiplexer.
interface dmux_8ch_stream_if;
  import dmux_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_bcast;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/dmux_8ch_stream_chan_reg.sv
// One-entry holding register for a single output channel.
// A load wins over a pop, so drain and refill in the same cycle leaves no bubble.
module dmux_chan_reg
  import dmux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             can_take
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  // Holding register: reset, load, pop (data kept), or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (out_ready && valid_r) begin
      valid_r <= 1'b0;
      data_r  <= data_r;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

  assign can_take  = ~valid_r | out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

endmodule

// File: rtl/dmux_8ch_stream.sv
// Registered 1-to-8 byte demultiplexer with per-channel valid/ready and all-or-nothing broadcast.
// in_ready depends only on channel occupancy, out_ready, in_sel and in_bcast.
module dmux_8ch_stream
  import dmux_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  dmux_8ch_stream_if.slave   bus
);

  logic [CHANNELS-1:0] can_take_s;
  logic [CHANNELS-1:0] sel_onehot_s;
  logic [CHANNELS-1:0] load_s;
  logic [CHANNELS-1:0] out_valid_s;
  logic [WIDTH-1:0]    chan_data_s [CHANNELS];
  logic                in_ready_s;
  logic                xfer_s;

  // Select decode to a one-hot channel vector.
  always_comb begin
    sel_onehot_s = 8'h00;
    case (bus.in_sel)
      3'd0:    sel_onehot_s = 8'h01;
      3'd1:    sel_onehot_s = 8'h02;
      3'd2:    sel_onehot_s = 8'h04;
      3'd3:    sel_onehot_s = 8'h08;
      3'd4:    sel_onehot_s = 8'h10;
      3'd5:    sel_onehot_s = 8'h20;
      3'd6:    sel_onehot_s = 8'h40;
      3'd7:    sel_onehot_s = 8'h80;
      default: sel_onehot_s = 8'h00;
    endcase
  end

  // Acceptance and load fan-out; a broadcast needs every channel free at once.
  always_comb begin
    in_ready_s = 1'b0;
    load_s     = 8'h00;
    if (bus.in_bcast) begin
      in_ready_s = &can_take_s;
    end else begin
      in_ready_s = |(can_take_s & sel_onehot_s);
    end
    xfer_s = bus.in_valid & in_ready_s;
    if (xfer_s) begin
      load_s = bus.in_bcast ? 8'hFF : sel_onehot_s;
    end else begin
      load_s = 8'h00;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    dmux_chan_reg u_chan (
      .clk       (clk),
      .rst       (rst),
      .load      (load_s[k]),
      .load_data (bus.in_data),
      .out_ready (bus.out_ready[k]),
      .out_valid (out_valid_s[k]),
      .out_data  (chan_data_s[k]),
      .can_take  (can_take_s[k])
    );
  end

  // Flatten per-channel registers onto the output bus.
  always_comb begin
    bus.out_data = {(CHANNELS*WIDTH){1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      bus.out_data[chan_lsb(k) +: WIDTH] = chan_data_s[k];
    end
  end

  assign bus.out_valid = out_valid_s;
  assign bus.in_ready  = in_ready_s;

endmodule

// File: tb/tb_dmux_8ch_stream.sv
// Self-checking bench for dmux_8ch_stream: directed scenarios plus randomized traffic
// compared against a per-channel occupancy model.
module tb_dmux_8ch_stream;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [7:0] m_valid;
  logic [7:0] m_data [8];

  dmux_8ch_stream_if bus();

  dmux_8ch_stream dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_ready();
    logic [7:0] ct;
    ct = ~m_valid | bus.out_ready;
    if (bus.in_bcast) return &ct;
    return ct[bus.in_sel];
  endfunction

  function automatic logic [63:0] model_out();
    logic [63:0] v;
    v = 64'h0;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = m_data[k];
    return v;
  endfunction

  // Advance one clock edge and update the model from the inputs applied before it.
  task automatic tick();
    logic       fire;
    logic [7:0] orv;
    logic [7:0] d;
    logic [2:0] s;
    logic       b;
    logic       r;
    fire = bus.in_valid && model_ready();
    orv  = bus.out_ready;
    d    = bus.in_data;
    s    = bus.in_sel;
    b    = bus.in_bcast;
    r    = rst;
    @(posedge clk);
    if (r) begin
      m_valid = 8'h00;
      for (int k = 0; k < 8; k++) m_data[k] = 8'h00;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (fire && (b || s == k)) begin
          m_valid[k] = 1'b1;
          m_data[k]  = d;
        end else if (orv[k]) begin
          m_valid[k] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 8'hFF;
    bus.in_valid = 1'b0;
    bus.in_bcast = 1'b0;
    bus.in_sel = 3'd0;
    bus.in_data = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    bus.out_ready = 8'h00;
    #1;
    checks++;
    if (bus.out_valid !== 8'h00) begin
      failures++;
      $display("FAIL reset_valid got=%h exp=%h", bus.out_valid, 8'h00);
    end
    checks++;
    if (bus.out_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=%h", bus.out_data, 64'h0);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=%b", bus.in_ready, 1'b1);
    end
  endtask

  task automatic test_routed();
    bus.in_sel = 3'd5;
    bus.in_data = 8'hA5;
    bus.in_valid = 1'b1;
    bus.out_ready = 8'h00;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL routed_in_ready got=%b exp=%b", bus.in_ready, 1'b1);
    end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 8'h20) begin
      failures++;
      $display("FAIL routed_valid got=%h exp=%h", bus.out_valid, 8'h20);
    end
    checks++;
    if (bus.out_data !== 64'h0000_A500_0000_0000) begin
      failures++;
      $display("FAIL routed_data got=%h exp=%h", bus.out_data, 64'h0000_A500_0000_0000);
    end
  endtask

  task automatic test_backpressure();
    bus.in_sel = 3'd5;
    bus.in_data = 8'h3C;
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_in_ready_full got=%b exp=%b", bus.in_ready, 1'b0);
    end
    tick();
    checks++;
    if (bus.out_data[47:40] !== 8'hA5) begin
      failures++;
      $display("FAIL bp_hold got=%h exp=%h", bus.out_data[47:40], 8'hA5);
    end
    bus.in_sel = 3'd2;
    bus.in_data = 8'h11;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_in_ready_free got=%b exp=%b", bus.in_ready, 1'b1);
    end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 8'h24 || bus.out_data[23:16] !== 8'h11) begin
      failures++;
      $display("FAIL bp_other_chan got=%h/%h exp=%h/%h", bus.out_valid, bus.out_data[23:16], 8'h24, 8'h11);
    end
  endtask

  task automatic test_pop_load();
    bus.out_ready = 8'h20;
    bus.in_sel = 3'd5;
    bus.in_data = 8'h77;
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_data[47:40] !== 8'hA5 || bus.out_valid[5] !== 1'b1) begin
      failures++;
      $display("FAIL popload_consume got=%b/%h exp=%b/%h", bus.in_ready, bus.out_data[47:40], 1'b1, 8'hA5);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 8'h00;
    #1;
    checks++;
    if (bus.out_valid !== 8'h24 || bus.out_data[47:40] !== 8'h77) begin
      failures++;
      $display("FAIL popload_refill got=%h/%h exp=%h/%h", bus.out_valid, bus.out_data[47:40], 8'h24, 8'h77);
    end
  endtask

  task automatic test_broadcast();
    bus.in_bcast = 1'b1;
    bus.in_data = 8'hF0;
    bus.in_valid = 1'b1;
    bus.out_ready = 8'h00;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bcast_blocked_ready got=%b exp=%b", bus.in_ready, 1'b0);
    end
    tick();
    checks++;
    if (bus.out_valid !== 8'h24 || bus.out_data !== 64'h0000_7700_0011_0000) begin
      failures++;
      $display("FAIL bcast_blocked_state got=%h/%h exp=%h/%h", bus.out_valid, bus.out_data, 8'h24, 64'h0000_7700_0011_0000);
    end
    // Channel 5 is still full, so draining channel 2 alone is not enough.
    bus.out_ready = 8'h04;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bcast_partial_ready got=%b exp=%b", bus.in_ready, 1'b0);
    end
    bus.out_ready = 8'h24;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bcast_pass_ready got=%b exp=%b", bus.in_ready, 1'b1);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_bcast = 1'b0;
    bus.out_ready = 8'h00;
    #1;
    checks++;
    if (bus.out_valid !== 8'hFF || bus.out_data !== 64'hF0F0_F0F0_F0F0_F0F0) begin
      failures++;
      $display("FAIL bcast_pass_state got=%h/%h exp=%h/%h", bus.out_valid, bus.out_data, 8'hFF, 64'hF0F0_F0F0_F0F0_F0F0);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel = 3'd0;
    bus.in_data = 8'h55;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 8'h00 || bus.out_data !== 64'h0) begin
      failures++;
      $display("FAIL rst_mid got=%h/%h exp=%h/%h", bus.out_valid, bus.out_data, 8'h00, 64'h0);
    end
    tick();
    checks++;
    if (bus.out_valid !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_after got=%h exp=%h", bus.out_valid, 8'h00);
    end
  endtask

  task automatic test_random();
    logic hold;
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = 8'($urandom);
        bus.in_sel   = 3'($urandom);
        bus.in_bcast = ($urandom_range(0, 7) == 0);
      end
      bus.out_ready = 8'($urandom) & 8'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      checks++;
      if (bus.in_ready !== model_ready()) begin
        failures++;
        $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", i, bus.in_ready, model_ready());
      end
      hold = bus.in_valid && !model_ready() && !rst;
      tick();
      checks++;
      if (bus.out_valid !== m_valid) begin
        failures++;
        $display("FAIL rand_valid cyc=%0d got=%h exp=%h", i, bus.out_valid, m_valid);
      end
      checks++;
      if (bus.out_data !== model_out()) begin
        failures++;
        $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, bus.out_data, model_out());
      end
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_valid = 8'h00;
    for (int k = 0; k < 8; k++) m_data[k] = 8'h00;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.in_sel = 3'd0;
    bus.in_bcast = 1'b0;
    bus.out_ready = 8'h00;
    #2;
    test_reset();
    test_routed();
    test_backpressure();
    test_pop_load();
    test_broadcast();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
